control_unit: RTL
=================

// Module: control_unit
// PURPOSE
//  Microcode sequencer for the 8-bit ben_cpu. Tracks the T-state of the current
//  instruction and emits the 16-bit control word that drives bus enables,
//  register loads, ALU mode, PC and flags.
//  Sits in cpu between the instruction/flags registers and the datapath.
//  Variable-length instructions; halts on HLT until reset.
// PARAMETERS
//  STEP_W   3   width of T-state counter (T0..T4)
//  CTRL_W   16  control word width (fixed by bit map below)
// PORTS
//  i_clk     in   1   single system clock, all state on rising edge
//  i_rst     in   1   synchronous, active-high reset
//  i_run     in   1   1 = sequence; 0 = freeze step, force o_ctrl=0
//  i_ir      in   8   instruction register; opcode = i_ir[7:4]
//  i_flags   in   2   latched ALU flags {C,Z}: [1]=carry, [0]=zero
//  o_ctrl    out  16  control word, combinational from registered state + inputs
//  o_step    out  3   current T-state (0..4)
//  o_halted  out  1   1 after HLT executed, until reset
// BEHAVIOUR
//  Ctrl bits: 15 HLT,14 MI,13 RI,12 RO,11 IO,10 II,9 AI,8 AO,7 EO,6 SU,5 BI,
//   4 OI,3 CE,2 CO,1 J,0 FI.
//  Reset (i_rst=1 at edge): step<=0, halted<=0. While i_rst high o_ctrl=0.
//  Fetch, all ops: T0 = CO|MI; T1 = RO|II|CE. IR valid from T2.
//  Execute (opcode: steps, length incl. fetch):
//   0 NOP: none, len 2 | 1 LDA: T2 IO|MI, T3 RO|AI, len 4
//   2 ADD: T2 IO|MI, T3 RO|BI, T4 EO|AI|FI, len 5 | 3 SUB: as ADD, T4 adds SU
//   4 STA: T2 IO|MI, T3 AO|RI, len 4 | 5 LDI: T2 IO|AI, len 3
//   6 JMP: T2 IO|J, len 3 | 7 JC: T2 IO|J if C else 0, len 3
//   8 JZ: T2 IO|J if Z else 0, len 3 | E OUT: T2 AO|OI, len 3
//   F HLT: T2 HLT, len 3 | 9..D undefined: treated as NOP, len 2
//  Advance (i_run=1, not halted): step<=0 if step==len-1, else step+1.
//   Steps 0,1 always advance (opcode ignored there). No idle cycles.
//  Conditional jumps take len 3 whether taken or not (fixed timing).
//  Flags sampled combinationally at T2; FI of previous ADD/SUB already latched.
//  Halt: edge at HLT T2 sets halted<=1, step<=0. While halted: o_ctrl=16'h8000,
//   step held 0, i_run ignored; only i_rst clears.
//  i_run=0: step and halted hold, o_ctrl=0 (no repeated side effects).
//  Reset mid-instruction: abandons instruction; next cycle after release is T0.
//  i_rst has priority over i_run and halted.
// STRUCTURE
//  ben_cpu_pkg: opcode localparams (OP_NOP..OP_HLT), control bit indices
//   (CTL_HLT..CTL_FI), T-state constants T0..T4.
//  Sub-module microcode_rom: combinational (opcode, step, flags) ->
//   (ctrl word, last_step). control_unit holds step/halted regs and gating.
// TESTING
//  1 Reset 2 cycles -> o_ctrl=0, step 0, halted 0; release -> T0 0x4004, T1 0x1408.
//  2 i_ir=0x1F (LDA) -> T2 0x4800, T3 0x1200, next cycle step 0 (4 cycles/instr).
//  3 ADD then SUB -> T3 0x1020; T4 0x0281 (ADD), 0x02C1 (SUB); step wraps to 0.
//  4 JC with C=1 -> T2 0x0802; C=0 -> T2 0x0000; both return to T0 after 3 cycles.
//  5 i_ir=0xF0 -> T2 0x8000, then halted=1, o_ctrl=0x8000 10+ cycles; i_rst -> T0.
//  6 i_run=0 at ADD T3 for 3 cycles -> o_ctrl=0, step=3 held; i_run=1 -> 0x1020.

Source files
------------

// File: rtl/control_unit_pkg.sv
// Shared constants for the ben_cpu control path: opcodes, control-word bit
// positions, T-states and the per-opcode instruction length.
package ben_cpu_pkg;

    localparam int STEP_W = 3;
    localparam int CTRL_W = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int CTL_HLT = 15;
    localparam int CTL_MI  = 14;
    localparam int CTL_RI  = 13;
    localparam int CTL_RO  = 12;
    localparam int CTL_IO  = 11;
    localparam int CTL_II  = 10;
    localparam int CTL_AI  = 9;
    localparam int CTL_AO  = 8;
    localparam int CTL_EO  = 7;
    localparam int CTL_SU  = 6;
    localparam int CTL_BI  = 5;
    localparam int CTL_OI  = 4;
    localparam int CTL_CE  = 3;
    localparam int CTL_CO  = 2;
    localparam int CTL_J   = 1;
    localparam int CTL_FI  = 0;

    typedef enum logic [STEP_W-1:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } tstate_t;

    function automatic logic [CTRL_W-1:0] cbit(input int idx);
        return CTRL_W'(1) << idx;
    endfunction

    // Total T-states including the two fetch steps; undefined opcodes run as NOP.
    function automatic logic [STEP_W-1:0] instr_len(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA:                                 return 3'd4;
            OP_ADD, OP_SUB:                                 return 3'd5;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT:   return 3'd3;
            default:                                        return 3'd2;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Bundle between the sequencer and the rest of ben_cpu: run/instruction/flags
// in, control word and sequencer state out.
interface control_unit_if;
    import ben_cpu_pkg::*;

    logic              i_run;
    logic [7:0]        i_ir;
    logic [1:0]        i_flags;
    logic [CTRL_W-1:0] o_ctrl;
    logic [STEP_W-1:0] o_step;
    logic              o_halted;

    // No handshake: inputs are level-sampled every cycle, outputs are valid every cycle.
    modport master (
        output i_run, i_ir, i_flags,
        input  o_ctrl, o_step, o_halted
    );

    modport slave (
        input  i_run, i_ir, i_flags,
        output o_ctrl, o_step, o_halted
    );
endinterface

// File: rtl/control_unit_microcode_rom.sv
// Combinational microcode: (opcode, T-state, flags) -> control word and a flag
// marking the final T-state of the instruction.
module control_unit_microcode_rom
    import ben_cpu_pkg::*;
(
    input  logic [3:0]        op,
    input  tstate_t           step,
    input  logic [1:0]        flags,
    output logic [CTRL_W-1:0] ctrl,
    output logic              last
);

    logic [STEP_W-1:0] step_v;
    logic              flag_c;
    logic              flag_z;

    assign step_v = step;
    assign flag_c = flags[1];
    assign flag_z = flags[0];

    always_comb begin
        ctrl = '0;
        case (step)
            T0: ctrl = cbit(CTL_CO) | cbit(CTL_MI);
            T1: ctrl = cbit(CTL_RO) | cbit(CTL_II) | cbit(CTL_CE);
            T2: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: ctrl = cbit(CTL_IO) | cbit(CTL_MI);
                    OP_LDI: ctrl = cbit(CTL_IO) | cbit(CTL_AI);
                    OP_JMP: ctrl = cbit(CTL_IO) | cbit(CTL_J);
                    OP_JC:  ctrl = flag_c ? (cbit(CTL_IO) | cbit(CTL_J)) : '0;
                    OP_JZ:  ctrl = flag_z ? (cbit(CTL_IO) | cbit(CTL_J)) : '0;
                    OP_OUT: ctrl = cbit(CTL_AO) | cbit(CTL_OI);
                    OP_HLT: ctrl = cbit(CTL_HLT);
                    default: ctrl = '0;
                endcase
            end
            T3: begin
                case (op)
                    OP_LDA:         ctrl = cbit(CTL_RO) | cbit(CTL_AI);
                    OP_ADD, OP_SUB: ctrl = cbit(CTL_RO) | cbit(CTL_BI);
                    OP_STA:         ctrl = cbit(CTL_AO) | cbit(CTL_RI);
                    default:        ctrl = '0;
                endcase
            end
            T4: begin
                case (op)
                    OP_ADD:  ctrl = cbit(CTL_EO) | cbit(CTL_AI) | cbit(CTL_FI);
                    OP_SUB:  ctrl = cbit(CTL_EO) | cbit(CTL_AI) | cbit(CTL_FI) | cbit(CTL_SU);
                    default: ctrl = '0;
                endcase
            end
            default: ctrl = '0;
        endcase
    end

    // Conditional jumps keep len 3 whether taken or not, so timing never depends on flags.
    assign last = (step_v == instr_len(op) - 3'd1);

endmodule

// File: rtl/control_unit.sv
// ben_cpu sequencer: holds the T-state counter and halt latch, gates the
// microcode word by reset, halt and run.
module control_unit
    import ben_cpu_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    control_unit_if.slave  bus
);

    tstate_t           step_q;
    tstate_t           step_d;
    logic              halted_q;
    logic              halted_d;
    logic [3:0]        opcode;
    logic [CTRL_W-1:0] rom_ctrl;
    logic              rom_last;

    assign opcode = bus.i_ir[7:4];

    control_unit_microcode_rom u_rom (
        .op    (opcode),
        .step  (step_q),
        .flags (bus.i_flags),
        .ctrl  (rom_ctrl),
        .last  (rom_last)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        if (halted_q) begin
            step_d = T0;
        end else if (bus.i_run) begin
            if (opcode == OP_HLT && step_q == T2) begin
                halted_d = 1'b1;
                step_d   = T0;
            end else if (rom_last || step_q == T4) begin
                step_d = T0;
            end else begin
                step_d = tstate_t'(step_q + 3'd1);
            end
        end
    end

    // Freezing with i_run=0 must not repeat side effects, so the word is blanked.
    always_comb begin
        bus.o_ctrl = '0;
        if (i_rst) begin
            bus.o_ctrl = '0;
        end else if (halted_q) begin
            bus.o_ctrl = cbit(CTL_HLT);
        end else if (bus.i_run) begin
            bus.o_ctrl = rom_ctrl;
        end
    end

    assign bus.o_step   = step_q;
    assign bus.o_halted = halted_q;

endmodule
